// File: rtl/snn_spike_readout.sv
// Spike-count readout: accumulates N_T spike vectors, then argmax-scans one neuron per cycle.
// Result pulses N_IN+1 cycles after the final vector; no backpressure, vectors outside ACCUM flag err_overrun.
module snn_spike_readout #(
  parameter int N_IN  = 30,
  parameter int N_T   = 25,
  parameter int CNT_W = 8,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             spk_valid,
  input  logic [N_IN-1:0]  spk_bits,
  output logic             busy,
  output logic             class_valid,
  output logic [IDX_W-1:0] class_idx,
  output logic [CNT_W-1:0] max_count,
  output logic             err_overrun
);

  localparam int STEP_W = (N_T > 1) ? $clog2(N_T) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, OUT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt [N_IN];
  logic [STEP_W-1:0] step;
  logic [IDX_W-1:0]  scan_idx, run_idx;
  logic [CNT_W-1:0]  run_max, scan_cnt;
  logic              last_step, last_scan, take, accum_hit;

  assign last_step = (step == STEP_W'(N_T - 1));
  assign last_scan = (scan_idx == IDX_W'(N_IN - 1));
  assign accum_hit = (state == ACCUM) && spk_valid;
  assign take      = (scan_cnt > run_max);

  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (scan_idx == IDX_W'(i)) scan_cnt = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state == ACCUM) || (state == SCAN);
    class_valid = (state == OUT);
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ACCUM:   if (spk_valid && last_step) state_nxt = SCAN;
        SCAN:    if (last_scan) state_nxt = OUT;
        OUT:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-neuron saturating counters; counts persist after OUT until the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else if (accum_hit) begin
      for (int i = 0; i < N_IN; i++) begin
        if (spk_bits[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step        <= '0;
      scan_idx    <= '0;
      run_idx     <= '0;
      run_max     <= '0;
      class_idx   <= '0;
      max_count   <= '0;
      err_overrun <= '0;
    end else if (clear) begin
      step        <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (spk_valid && (state != ACCUM)) err_overrun <= 1'b1;
      if (accum_hit) begin
        step <= last_step ? '0 : step + STEP_W'(1);
        if (last_step) begin
          scan_idx <= '0;
          run_idx  <= '0;
          run_max  <= '0;
        end
      end
      if (state == SCAN) begin
        scan_idx <= scan_idx + IDX_W'(1);
        if (take) begin
          run_max <= scan_cnt;
          run_idx <= scan_idx;
        end
        // Fold in the last comparison here so the result is visible in the OUT cycle.
        if (last_scan) begin
          class_idx <= take ? scan_idx : run_idx;
          max_count <= take ? scan_cnt : run_max;
        end
      end
    end
  end

endmodule
